// File: rtl/d_card_driver_pkg.sv
// Shared definitions for the card-side SD data-line engine: states, block
// geometry, CRC status tokens and the CCITT polynomial.
package d_card_driver_pkg;

  localparam int          BLOCK_NIBBLES = 1024;
  localparam int          CRC_LEN       = 16;
  localparam logic [2:0]  TOKEN_OK      = 3'b010;
  localparam logic [2:0]  TOKEN_ERR     = 3'b101;
  localparam logic [15:0] CRC_POLY      = 16'h1021;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_CRC,
    TX_END,
    RX_WAIT,
    RX_DATA,
    RX_CRC,
    RX_END,
    NWR,
    TOKEN,
    BUSY
  } state_t;

endpackage

// File: rtl/d_card_driver_if.sv
// Block-RAM port between the data-line engine (master) and the RAM (slave).
interface d_card_driver_if #(
  parameter int AW = 10
);
  logic [AW-1:0] oaddr;
  logic [3:0]    irdata;
  logic [3:0]    owdata;
  logic          owrite_en;

  modport master (output oaddr, output owdata, output owrite_en, input irdata);
  modport slave  (input oaddr, input owdata, input owrite_en, output irdata);
endinterface

// File: rtl/crc16.sv
// Serial CCITT CRC16 for one SD data line, zero seed; unload shifts the
// remainder out MSB first on ocrc_msb.
module crc16 (
  input  logic iclk,
  input  logic irst,
  input  logic iclear,
  input  logic ienable,
  input  logic ishift,
  input  logic idin,
  output logic ocrc_msb
);
  import d_card_driver_pkg::*;

  logic [15:0] crc;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      crc <= '0;
    end else if (iclear) begin
      crc <= '0;
    end else if (ienable) begin
      crc <= {crc[14:0], 1'b0} ^ ((idin ^ crc[15]) ? CRC_POLY : 16'h0000);
    end else if (ishift) begin
      crc <= {crc[14:0], 1'b0};
    end
  end

  assign ocrc_msb = crc[15];

endmodule

// File: rtl/d_card_driver.sv
// Card-side SD 4-bit data engine: streams a RAM block to the host on reads and
// receives, CRC-checks and acknowledges a block from the host on writes.
module d_card_driver #(
  parameter int BLOCK_NIBBLES = d_card_driver_pkg::BLOCK_NIBBLES,
  parameter int CRC_LEN       = d_card_driver_pkg::CRC_LEN
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic [3:0]             idata_sd,
  output logic [3:0]             odata_sd,
  output logic                   ooe,
  input  logic                   iread_start,
  input  logic                   iwrite_start,
  d_card_driver_if.master        ram,
  input  logic                   ibusy_release,
  output logic                   ocrc_fail,
  output logic                   odone
);
  import d_card_driver_pkg::*;

  localparam int CW = $clog2(BLOCK_NIBBLES) + 1;
  localparam int AW = CW - 1;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    sd_q;
  logic [3:0]    crc_msb;
  logic [3:0]    crc_din;
  logic          crc_clear, crc_en, crc_shift;
  logic          fail_set, fail_clr;
  logic [4:0]    tok_seq;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state <= IDLE;
      cnt   <= '0;
      sd_q  <= 4'hF;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      sd_q  <= idata_sd;
    end
  end

  // The status token carries the CRC verdict, framed by a start and end bit.
  assign tok_seq = {1'b0, (ocrc_fail ? TOKEN_ERR : TOKEN_OK), 1'b1};

  always_comb begin
    next_state    = state;
    cnt_next      = cnt;
    odata_sd      = 4'hF;
    ooe           = 1'b0;
    ram.oaddr     = cnt[AW-1:0];
    ram.owdata    = 4'h0;
    ram.owrite_en = 1'b0;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;
    crc_shift     = 1'b0;
    crc_din       = 4'h0;
    fail_set      = 1'b0;
    fail_clr      = 1'b0;
    case (state)
      IDLE: begin
        crc_clear = 1'b1;
        cnt_next  = '0;
        if (iread_start) begin
          next_state = TX_START;
          fail_clr   = 1'b1;
        end else if (iwrite_start) begin
          next_state = RX_WAIT;
          fail_clr   = 1'b1;
        end
      end
      TX_START: begin
        ooe        = 1'b1;
        odata_sd   = 4'h0;
        crc_clear  = 1'b1;
        cnt_next   = CW'(1);
        next_state = TX_DATA;
      end
      // Address runs one ahead of the driven nibble to cover the RAM latency.
      TX_DATA: begin
        ooe      = 1'b1;
        odata_sd = ram.irdata;
        crc_en   = 1'b1;
        crc_din  = ram.irdata;
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(BLOCK_NIBBLES)) begin
          next_state = TX_CRC;
          cnt_next   = '0;
        end
      end
      TX_CRC: begin
        ooe       = 1'b1;
        odata_sd  = crc_msb;
        crc_shift = 1'b1;
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(CRC_LEN - 1)) begin
          next_state = TX_END;
          cnt_next   = '0;
        end
      end
      TX_END: begin
        ooe        = 1'b1;
        odata_sd   = 4'hF;
        next_state = IDLE;
      end
      RX_WAIT: begin
        crc_clear = 1'b1;
        if (sd_q == 4'h0) begin
          next_state = RX_DATA;
          cnt_next   = '0;
        end
      end
      RX_DATA: begin
        ram.owrite_en = 1'b1;
        ram.owdata    = sd_q;
        crc_en        = 1'b1;
        crc_din       = sd_q;
        cnt_next      = cnt + CW'(1);
        if (cnt == CW'(BLOCK_NIBBLES - 1)) begin
          next_state = RX_CRC;
          cnt_next   = '0;
        end
      end
      RX_CRC: begin
        crc_shift = 1'b1;
        fail_set  = (sd_q != crc_msb);
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(CRC_LEN - 1)) begin
          next_state = RX_END;
          cnt_next   = '0;
        end
      end
      RX_END: begin
        fail_set   = (sd_q != 4'hF);
        next_state = NWR;
      end
      NWR: begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(1)) begin
          next_state = TOKEN;
          cnt_next   = '0;
        end
      end
      TOKEN: begin
        ooe      = 1'b1;
        odata_sd = {3'b111, tok_seq[3'd4 - cnt[2:0]]};
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(4)) begin
          next_state = ocrc_fail ? IDLE : BUSY;
          cnt_next   = '0;
        end
      end
      // cnt[0] marks that the release was seen; one D0-high cycle follows.
      BUSY: begin
        ooe = 1'b1;
        if (cnt[0]) begin
          odata_sd   = 4'hF;
          next_state = IDLE;
        end else begin
          odata_sd = 4'hE;
          if (ibusy_release) begin
            cnt_next = CW'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ocrc_fail <= 1'b0;
      odone     <= 1'b0;
    end else begin
      if (fail_clr) begin
        ocrc_fail <= 1'b0;
      end else if (fail_set) begin
        ocrc_fail <= 1'b1;
      end
      odone <= (state != IDLE) && (next_state == IDLE);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_line_crc
    crc16 u_crc (
      .iclk     (iclk),
      .irst     (irst),
      .iclear   (crc_clear),
      .ienable  (crc_en),
      .ishift   (crc_shift),
      .idin     (crc_din[i]),
      .ocrc_msb (crc_msb[i])
    );
  end

endmodule
